// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and opcode constants for the fetch sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  // Opcode field positions
  localparam int BR_CLASS_BIT = 15;
  localparam int NT_HINT_BIT  = 14;

  // Major opcode that stops the sequencer
  localparam logic [3:0] HALT_OP = 4'hF;

  // Sequential PC increment
  localparam int PC_STEP = 2;

  // True when the major opcode field encodes HALT
  function automatic logic is_halt_op(input logic [3:0] op);
    return (op == HALT_OP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_sequencer_next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
// Next-PC arithmetic: sequential step, or halfword-aligned branch target
// when a resolved branch is being applied and was taken.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module next_pc_sel #(
  parameter int ADDR_W = 32,
  parameter int STEP   = 2
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              taken,
  input  logic [ADDR_W-1:0] target,
  input  logic              sel,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] aligned_target;

  // Add wraps naturally modulo 2^ADDR_W
  assign seq_pc         = pc + ADDR_W'(STEP);
  // Odd targets are truncated to the halfword boundary
  assign aligned_target = {target[ADDR_W-1:1], 1'b0};
  assign next_pc        = (sel && taken) ? aligned_target : seq_pc;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
// Owns the PC, fetches one instruction at a time, offers it to decode and
// chooses the next PC (sequential, static not-taken, or resolved branch).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                PC_STEP  = fetch_pkg::PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               dec_ready,
  input  logic               br_valid,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              resolving;
  logic              needs_resolve;

  // Target selection only applies while a branch outcome is being consumed
  assign resolving     = (state == ST_RESOLVE);
  // Branch-class without the static not-taken hint waits for execute
  assign needs_resolve = instr[BR_CLASS_BIT] && !instr[NT_HINT_BIT];

  next_pc_sel #(
    .ADDR_W (ADDR_W),
    .STEP   (PC_STEP)
  ) u_next_pc_sel (
    .pc      (pc),
    .taken   (br_taken),
    .target  (br_target),
    .sel     (resolving),
    .next_pc (next_pc)
  );

  // The fetch address is always the architectural PC register
  assign imem_addr = pc;

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end

        ST_FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
            imem_req <= 1'b0;
            if (is_halt_op(imem_rdata[INSTR_W-1 -: 4])) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state       <= ST_ISSUE;
              instr_valid <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          if (dec_ready) begin
            instr_valid <= 1'b0;
            if (needs_resolve) begin
              state <= ST_RESOLVE;
            end else begin
              pc       <= next_pc;
              state    <= ST_FETCH;
              imem_req <= 1'b1;
            end
          end
        end

        ST_RESOLVE: begin
          if (br_valid) begin
            pc       <= next_pc;
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end

        ST_HALT: begin
          state <= ST_HALT;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Directed bench with a handshake-level reference model and per-cycle compare.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_sequencer;

  localparam logic [19:0] NOP  = 20'h01234;
  localparam logic [19:0] BR   = 20'h28ABC;
  localparam logic [19:0] NT   = 20'h3C123;
  localparam logic [19:0] HALT = 20'hF0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [19:0] imem_rdata = '0;
  logic        instr_valid;
  logic [19:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        halted;

  int total = 0;
  int bad   = 0;

  pc_fetch_sequencer #(
    .ADDR_W   (32),
    .INSTR_W  (20),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .dec_ready   (dec_ready),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (handshake level) ----------------
  logic        chk_on = 1'b0;
  logic        m_start, m_req, m_valid, m_halted, m_await;
  logic [31:0] m_fpc, m_ipc;
  logic [19:0] m_instr;

  always @(posedge clk) begin
    if (rst) begin
      chk_on   <= 1'b1;
      m_start  <= 1'b1;
      m_req    <= 1'b0;
      m_valid  <= 1'b0;
      m_halted <= 1'b0;
      m_await  <= 1'b0;
      m_fpc    <= 32'h0;
      m_ipc    <= 32'h0;
      m_instr  <= 20'h0;
    end else if (m_start) begin
      m_start <= 1'b0;
      m_req   <= 1'b1;
    end else if (m_req && imem_ack) begin
      m_req   <= 1'b0;
      m_instr <= imem_rdata;
      m_ipc   <= m_fpc;
      if (imem_rdata[19:16] == 4'hF) m_halted <= 1'b1;
      else                           m_valid  <= 1'b1;
    end else if (m_valid && dec_ready) begin
      m_valid <= 1'b0;
      if (m_instr[15] && !m_instr[14]) begin
        m_await <= 1'b1;
      end else begin
        m_fpc <= m_ipc + 32'd2;
        m_req <= 1'b1;
      end
    end else if (m_await && br_valid) begin
      m_await <= 1'b0;
      m_fpc   <= br_taken ? (br_target & 32'hFFFF_FFFE) : (m_ipc + 32'd2);
      m_req   <= 1'b1;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_imem_req",    32'(imem_req),    32'(m_req));
      chk("m_imem_addr",   imem_addr,        m_fpc);
      chk("m_instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("m_instr",       32'(instr),       32'(m_instr));
      chk("m_instr_pc",    instr_pc,         m_ipc);
      chk("m_halted",      32'(halted),      32'(m_halted));
    end
  end

  // ---------------- directed stimulus tasks (entered at a negedge) ----------------
  task automatic fetch(input logic [31:0] exp_addr, input logic [19:0] data, input int delay);
    int n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_addr);
    repeat (delay) begin
      imem_rdata = 20'($urandom);
      @(negedge clk);
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, exp_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 20'($urandom);
    if (data == HALT) begin
      chk("halt_set", 32'(halted), 32'd1);
      chk("halt_no_valid", 32'(instr_valid), 32'd0);
    end else begin
      chk("valid_after_ack", 32'(instr_valid), 32'd1);
      chk("instr_lit", 32'(instr), 32'(data));
      chk("instr_pc_lit", instr_pc, exp_addr);
    end
  endtask

  task automatic issue(input int delay);
    logic [19:0] held;
    held = instr;
    repeat (delay) begin
      @(negedge clk);
      chk("valid_hold", 32'(instr_valid), 32'd1);
      chk("instr_stable", 32'(instr), 32'(held));
    end
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    chk("valid_drop", 32'(instr_valid), 32'd0);
  endtask

  task automatic resolve(input logic taken, input logic [31:0] target);
    chk("resolve_no_req", 32'(imem_req), 32'd0);
    br_valid  = 1'b1;
    br_taken  = taken;
    br_target = target;
    @(negedge clk);
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    br_target = $urandom;
    chk("resolve_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and first-request latency
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req",    32'(imem_req),    32'd0);
    chk("rst_addr",   imem_addr,        32'h0);
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_instr",  32'(instr),       32'd0);
    chk("rst_halted", 32'(halted),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_cycle2", 32'(imem_req), 32'd1);

    // Zero-wait stream of non-branch instructions
    for (int i = 0; i < 3; i++) begin
      fetch(32'(2 * i), NOP ^ 20'(i), 0);
      issue(0);
      chk("two_cycle_refetch", 32'(imem_req), 32'd1);
    end
    chk("seq_addr_6", imem_addr, 32'h6);

    // Wait states on memory and decode
    fetch(32'h6, NOP, 3);
    issue(2);
    for (int a = 8; a < 16; a += 2) begin
      fetch(32'(a), NOP, 0);
      issue(0);
    end

    // Resolved branch taken, odd target truncated
    fetch(32'h10, BR, 0);
    issue(0);
    resolve(1'b1, 32'h41);
    chk("br_taken_addr", imem_addr, 32'h40);
    fetch(32'h40, BR, 0);
    issue(0);
    resolve(1'b1, 32'h10);

    // Same branch not taken
    fetch(32'h10, BR, 1);
    issue(1);
    resolve(1'b0, 32'h41);
    chk("br_not_taken_addr", imem_addr, 32'h12);
    fetch(32'h12, BR, 0);
    issue(0);
    resolve(1'b1, 32'h20);

    // Static not-taken with stray br_valid pulses
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h80;
    fetch(32'h20, NT, 0);
    issue(1);
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    chk("static_nt_addr", imem_addr, 32'h22);

    // Wrap at top of address space
    fetch(32'h22, BR, 0);
    issue(0);
    resolve(1'b1, 32'hFFFF_FFFF);
    fetch(32'hFFFF_FFFE, NOP, 0);
    issue(0);
    chk("wrap_addr", imem_addr, 32'h0);

    // HALT is sticky, no further requests
    fetch(32'h0, HALT, 0);
    dec_ready = 1'b1;
    br_valid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("halt_no_req", 32'(imem_req), 32'd0);
      chk("halt_sticky", 32'(halted), 32'd1);
    end
    dec_ready = 1'b0;
    br_valid  = 1'b0;

    // Reset clears HALT; then reset mid-FETCH with a pending ack
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("halt_cleared", 32'(halted), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = HALT;
    rst        = 1'b1;
    @(negedge clk);
    chk("midfetch_req_drop", 32'(imem_req), 32'd0);
    chk("midfetch_addr", imem_addr, 32'h0);
    chk("midfetch_halted", 32'(halted), 32'd0);
    chk("midfetch_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_ignored", 32'(instr_valid), 32'd0);
    chk("late_ack_no_halt", 32'(halted), 32'd0);
    fetch(32'h0, NOP, 0);
    issue(0);
    chk("after_reset_next", imem_addr, 32'h2);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
